// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO register
// offsets and STATUS bit positions.
package dmem_responder_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] OFF_CYCLE   = 4'h0;
  localparam logic [3:0] OFF_CMP     = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_SCRATCH = 4'hC;

  localparam int ST_MATCH   = 0;
  localparam int ST_ERR     = 1;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_CLR = 31;

endpackage

// File: rtl/dmem_lane_steer.sv
// Byte/halfword lane steering between the right-justified bus view and a
// little-endian 32-bit storage word.
module dmem_lane_steer
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rjust,
  output logic        misalign
);

  // Decode enables, replicate write data into every lane, extract read lanes
  always_comb begin
    be       = 4'b0000;
    wword    = 32'h0000_0000;
    rjust    = 32'h0000_0000;
    misalign = 1'b0;
    case (size)
      SZ_WORD: begin
        misalign = (lane != 2'b00);
        be       = 4'b1111;
        wword    = wdata;
        rjust    = rword;
      end
      SZ_HALF: begin
        misalign = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wword    = {wdata[15:0], wdata[15:0]};
        rjust    = {16'h0000, (lane[1] ? rword[31:16] : rword[15:0])};
      end
      SZ_BYTE: begin
        misalign = 1'b0;
        be       = 4'b0001 << lane;
        wword    = {4{wdata[7:0]}};
        rjust    = {24'h00_0000, rword[{lane, 3'b000} +: 8]};
      end
      default: begin
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side responder for the single-cycle MIPS core: word RAM with lane
// steering plus a 16-byte MMIO window (cycle counter, compare, status, scratch).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] RAM_BASE    = 32'h1001_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h1001_F000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        err,
  output logic        irq
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] cycle_r, cmp_r, scratch_r;
  logic        match_r, errf_r;
  logic [7:0]  errcnt_r;

  logic [31:0] cycle_nxt_s, cmp_nxt_s, scratch_nxt_s;
  logic        match_nxt_s, errf_nxt_s;
  logic [7:0]  errcnt_nxt_s;

  logic [31:0] ram_off_s, ram_word_s, mmio_word_s, status_word_s;
  logic [31:0] rword_s, wword_s, rjust_s;
  logic [AW-1:0] widx_s;
  logic [3:0]  be_s;
  logic        in_ram_s, in_mmio_s, misalign_s;
  logic        rd_ok_s, wr_ok_s, ram_we_s;
  logic        cmp_we_s, scratch_we_s, status_we_s;

  // Address decode; the lower bound check guards against subtraction wrap
  assign ram_off_s  = addr - RAM_BASE;
  assign in_ram_s   = (addr >= RAM_BASE) && (ram_off_s < RAM_BYTES);
  assign in_mmio_s  = (addr[31:4] == MMIO_BASE[31:4]);
  assign widx_s     = ram_off_s[AW+1:2];
  assign ram_word_s = mem[widx_s];

  // Assemble STATUS from its individual fields
  always_comb begin
    status_word_s                        = 32'h0000_0000;
    status_word_s[ST_MATCH]              = match_r;
    status_word_s[ST_ERR]                = errf_r;
    status_word_s[ST_CNT_LSB +: 8]       = errcnt_r;
  end

  // MMIO read mux
  always_comb begin
    mmio_word_s = 32'h0000_0000;
    case (addr[3:0])
      OFF_CYCLE:   mmio_word_s = cycle_r;
      OFF_CMP:     mmio_word_s = cmp_r;
      OFF_STATUS:  mmio_word_s = status_word_s;
      OFF_SCRATCH: mmio_word_s = scratch_r;
      default:     mmio_word_s = 32'h0000_0000;
    endcase
  end

  assign rword_s = in_mmio_s ? mmio_word_s : ram_word_s;

  dmem_lane_steer u_steer (
    .size     (size),
    .lane     (addr[1:0]),
    .wdata    (wdata),
    .rword    (rword_s),
    .be       (be_s),
    .wword    (wword_s),
    .rjust    (rjust_s),
    .misalign (misalign_s)
  );

  assign err = cs & ((rd == wr) | (size == SZ_RSVD) | misalign_s |
                     ~(in_ram_s | in_mmio_s) | (in_mmio_s & (size != SZ_WORD)));

  // A write landing in a reset cycle is dropped so reset leaves a clean state
  assign rd_ok_s  = cs & ~err & rd;
  assign wr_ok_s  = cs & ~err & wr & ~reset;
  assign ram_we_s = wr_ok_s & in_ram_s;
  assign rdata    = rd_ok_s ? rjust_s : 32'h0000_0000;
  assign irq      = match_r;

  // MMIO write strobes; CYCLE is read-only so writes to it fall through silently
  always_comb begin
    cmp_we_s     = 1'b0;
    scratch_we_s = 1'b0;
    status_we_s  = 1'b0;
    if (wr_ok_s && in_mmio_s) begin
      case (addr[3:0])
        OFF_CMP:     cmp_we_s     = 1'b1;
        OFF_STATUS:  status_we_s  = 1'b1;
        OFF_SCRATCH: scratch_we_s = 1'b1;
        default:     cmp_we_s     = 1'b0;
      endcase
    end else begin
      cmp_we_s = 1'b0;
    end
  end

  // Register next-state: hardware set events take priority over software clears
  always_comb begin
    cycle_nxt_s   = cycle_r + 32'd1;
    cmp_nxt_s     = cmp_we_s ? wdata : cmp_r;
    scratch_nxt_s = scratch_we_s ? wdata : scratch_r;

    if (cycle_r == cmp_r) begin
      match_nxt_s = 1'b1;
    end else if (status_we_s && wdata[ST_MATCH]) begin
      match_nxt_s = 1'b0;
    end else begin
      match_nxt_s = match_r;
    end

    if (err) begin
      errf_nxt_s = 1'b1;
    end else if (status_we_s && wdata[ST_ERR]) begin
      errf_nxt_s = 1'b0;
    end else begin
      errf_nxt_s = errf_r;
    end

    if (status_we_s && wdata[ST_CNT_CLR]) begin
      errcnt_nxt_s = 8'h00;
    end else if (err && (errcnt_r != 8'hFF)) begin
      errcnt_nxt_s = errcnt_r + 8'd1;
    end else begin
      errcnt_nxt_s = errcnt_r;
    end
  end

  // MMIO state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_r   <= 32'h0000_0000;
      cmp_r     <= 32'h0000_0000;
      scratch_r <= 32'h0000_0000;
      match_r   <= 1'b0;
      errf_r    <= 1'b0;
      errcnt_r  <= 8'h00;
    end else begin
      cycle_r   <= cycle_nxt_s;
      cmp_r     <= cmp_nxt_s;
      scratch_r <= scratch_nxt_s;
      match_r   <= match_nxt_s;
      errf_r    <= errf_nxt_s;
      errcnt_r  <= errcnt_nxt_s;
    end
  end

  // RAM byte-lane writes; contents are intentionally not initialised by reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem[widx_s][8*b +: 8] <= wword_s[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: lane steering, MMIO registers,
// error accounting, compare interrupt, counter wrap and reset behaviour.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [31:0] RB = 32'h1001_0000;
  localparam logic [31:0] MB = 32'h1001_F000;

  logic        clk, reset, cs, rd, wr, err, irq;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cyc_m;
  logic [31:0] k;

  dmem_responder dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .rd    (rd),
    .wr    (wr),
    .size  (size),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .err   (err),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: cleared by reset, otherwise +1 per edge
  always @(posedge clk) cyc_m <= reset ? 32'd0 : cyc_m + 32'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string nm, input logic [31:0] v);
    sb.push_back('{tag: nm, val: v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0; size = SZ_WORD;
    addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic drv(input string nm, input logic r, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee);
    cs = 1'b1; rd = r; wr = w; size = sz; addr = a; wdata = d;
    push(nm, er);
    push({nm, "_err"}, {31'd0, ee});
    #1;
    chk(rdata);
    chk({31'd0, err});
  endtask

  task automatic xfer(input string nm, input logic r, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee);
    nxt();
    drv(nm, r, w, sz, a, d, er, ee);
  endtask

  task automatic chk_irq(input string nm, input logic ev);
    push(nm, {31'd0, ev});
    chk({31'd0, irq});
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; size = SZ_WORD;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);

    // Reset state (reads are combinational, so they work while reset is held)
    xfer("rst_status", 1, 0, SZ_WORD, MB + 32'h8, 32'h0, 32'h0, 0);
    chk_irq("rst_irq", 0);
    xfer("rst_cycle", 1, 0, SZ_WORD, MB + 32'h0, 32'h0, 32'h0, 0);
    nxt();
    push("idle_rdata", 32'h0); push("idle_err", 32'h0);
    #1; chk(rdata); chk({31'd0, err});
    reset = 1'b0;

    // CYCLE 0 meets CMP 0 at the first running edge
    xfer("wr_cmp", 0, 1, SZ_WORD, MB + 32'h4, 32'd20, 32'h0, 0);
    chk_irq("irq_cmp0", 1);
    xfer("w1c_match", 0, 1, SZ_WORD, MB + 32'h8, 32'h1, 32'h0, 0);
    xfer("rd_cmp", 1, 0, SZ_WORD, MB + 32'h4, 32'h0, 32'd20, 0);
    chk_irq("irq_cleared", 0);
    for (int i = 0; i < 100 && cyc_m != 32'd18; i++) nxt();
    xfer("cycle19", 1, 0, SZ_WORD, MB + 32'h0, 32'h0, 32'd19, 0);
    xfer("w1c_on_match", 0, 1, SZ_WORD, MB + 32'h8, 32'h1, 32'h0, 0);
    chk_irq("irq_pre_match", 0);
    nxt();
    chk_irq("irq_match_wins", 1);
    xfer("status_match", 1, 0, SZ_WORD, MB + 32'h8, 32'h0, 32'h1, 0);
    xfer("w1c_later", 0, 1, SZ_WORD, MB + 32'h8, 32'h1, 32'h0, 0);
    nxt();
    chk_irq("irq_w1c", 0);

    // Byte steering
    xfer("wr_w0", 0, 1, SZ_WORD, RB, 32'h1122_3344, 32'h0, 0);
    xfer("wr_b2", 0, 1, SZ_BYTE, RB + 32'h2, 32'hFFFF_FFAB, 32'h0, 0);
    xfer("rd_w0", 1, 0, SZ_WORD, RB, 32'h0, 32'h11AB_3344, 0);
    xfer("rd_b3", 1, 0, SZ_BYTE, RB + 32'h3, 32'h0, 32'h0000_0011, 0);
    xfer("rd_b0", 1, 0, SZ_BYTE, RB, 32'h0, 32'h0000_0044, 0);
    xfer("rd_h2", 1, 0, SZ_HALF, RB + 32'h2, 32'h0, 32'h0000_11AB, 0);

    // Halfword steering and misaligned halfword
    xfer("wr_w1", 0, 1, SZ_WORD, RB + 32'h4, 32'h0102_0304, 32'h0, 0);
    xfer("wr_h6", 0, 1, SZ_HALF, RB + 32'h6, 32'h5555_BEEF, 32'h0, 0);
    xfer("rd_h6", 1, 0, SZ_HALF, RB + 32'h6, 32'h0, 32'h0000_BEEF, 0);
    xfer("rd_w1", 1, 0, SZ_WORD, RB + 32'h4, 32'h0, 32'hBEEF_0304, 0);
    xfer("rd_h4", 1, 0, SZ_HALF, RB + 32'h4, 32'h0, 32'h0000_0304, 0);
    xfer("wr_h5_mis", 0, 1, SZ_HALF, RB + 32'h5, 32'h0000_7777, 32'h0, 1);
    xfer("status_mis", 1, 0, SZ_WORD, MB + 32'h8, 32'h0, 32'h0000_0102, 0);
    xfer("rd_w1_kept", 1, 0, SZ_WORD, RB + 32'h4, 32'h0, 32'hBEEF_0304, 0);

    // Error accounting
    xfer("clr_status", 0, 1, SZ_WORD, MB + 32'h8, 32'h8000_0002, 32'h0, 0);
    xfer("status_clr", 1, 0, SZ_WORD, MB + 32'h8, 32'h0, 32'h0, 0);
    xfer("err_unmapped", 1, 0, SZ_WORD, 32'h0000_0000, 32'h0, 32'h0, 1);
    xfer("err_mmio_byte", 1, 0, SZ_BYTE, MB + 32'hC, 32'h0, 32'h0, 1);
    xfer("err_size11", 1, 0, SZ_RSVD, RB, 32'h0, 32'h0, 1);
    xfer("err_rdwr", 1, 1, SZ_WORD, RB, 32'h0, 32'h0, 1);
    xfer("status_cnt4", 1, 0, SZ_WORD, MB + 32'h8, 32'h0, 32'h0000_0402, 0);
    xfer("err_past_end", 1, 0, SZ_WORD, RB + 32'h0000_2000, 32'h0, 32'h0, 1);
    xfer("err_none", 0, 0, SZ_WORD, RB, 32'h0, 32'h0, 1);
    xfer("wr_last", 0, 1, SZ_WORD, RB + 32'h0000_1FFC, 32'hA5A5_5A5A, 32'h0, 0);
    xfer("rd_last", 1, 0, SZ_WORD, RB + 32'h0000_1FFC, 32'h0, 32'hA5A5_5A5A, 0);
    for (int i = 0; i < 260; i++) xfer("err_sat", 1, 0, SZ_WORD, 32'h0000_0000, 32'h0, 32'h0, 1);
    xfer("status_sat", 1, 0, SZ_WORD, MB + 32'h8, 32'h0, 32'h0000_FF02, 0);
    xfer("clr_status2", 0, 1, SZ_WORD, MB + 32'h8, 32'h8000_0002, 32'h0, 0);
    xfer("status_clr2", 1, 0, SZ_WORD, MB + 32'h8, 32'h0, 32'h0, 0);
    xfer("wr_cycle_ign", 0, 1, SZ_WORD, MB + 32'h0, 32'h1234_5678, 32'h0, 0);
    xfer("rd_cycle_run", 1, 0, SZ_WORD, MB + 32'h0, 32'h0, cyc_m + 32'd1, 0);

    // Mid-access reset with state to clear
    xfer("wr_scratch", 0, 1, SZ_WORD, MB + 32'hC, 32'hCAFE_F00D, 32'h0, 0);
    xfer("rd_scratch", 1, 0, SZ_WORD, MB + 32'hC, 32'h0, 32'hCAFE_F00D, 0);
    k = cyc_m;
    xfer("wr_cmp_soon", 0, 1, SZ_WORD, MB + 32'h4, k + 32'd3, 32'h0, 0);
    nxt(); nxt(); nxt();
    chk_irq("irq_pre_reset", 1);
    xfer("err_pre_reset", 1, 0, SZ_WORD, 32'h0000_0000, 32'h0, 32'h0, 1);
    nxt();
    reset = 1'b1;
    drv("wr_scratch_rst", 0, 1, SZ_WORD, MB + 32'hC, 32'h5555_5555, 32'h0, 0);
    xfer("scratch_rst", 1, 0, SZ_WORD, MB + 32'hC, 32'h0, 32'h0, 0);
    chk_irq("irq_rst", 0);
    xfer("status_rst", 1, 0, SZ_WORD, MB + 32'h8, 32'h0, 32'h0, 0);
    xfer("ram_survives", 1, 0, SZ_WORD, RB, 32'h0, 32'h11AB_3344, 0);
    nxt();
    reset = 1'b0;

    // Counter wrap: preload the top value mid-cycle, then let one edge pass
    @(posedge clk);
    #2 force dut.cycle_r = 32'hFFFF_FFFF;
    #1 release dut.cycle_r;
    xfer("cycle_max", 1, 0, SZ_WORD, MB + 32'h0, 32'h0, 32'hFFFF_FFFF, 0);
    xfer("cycle_wrap", 1, 0, SZ_WORD, MB + 32'h0, 32'h0, 32'h0000_0000, 0);
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side bus responder for the single-cycle MIPS core; the target end of the core's dmem interface (chip select, read, write, size, address, write data, read data).
- Holds a word-organised data RAM with byte and halfword lane steering.
- Also decodes a small MMIO window: free-running cycle counter, compare/match interrupt, scratch register, sticky error status with an error counter.
- Reads complete in the same cycle, as the single-cycle core requires. Writes commit at the rising clock edge.

Parameters:
- DEPTH_WORDS, 2048: number of 32-bit RAM words; power of two.
- RAM_BASE, 32'h1001_0000: byte address of RAM word 0.
- MMIO_BASE, 32'h1001_F000: base of the 16-byte MMIO window; aligned to 16 bytes; must not overlap RAM.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  access valid this cycle; rd and wr are ignored when low.
- rd  in  1  read request.
- wr  in  1  write request.
- size  in  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
- addr  in  32  byte address.
- wdata  in  32  write data, right-justified: byte in [7:0], halfword in [15:0].
- rdata  out  32  read data, right-justified, zero-filled above the access width. The core performs sign extension.
- err  out  1  combinational: current access is illegal.
- irq  out  1  registered: compare-match sticky flag.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Clock and reset ports are named clk and reset.
- Reset clears CYCLE, CMP, SCRATCH, STATUS and the error count. irq becomes 0 on the first edge with reset high.
- Reset does not initialise RAM contents.
- RAM region: addr in [RAM_BASE, RAM_BASE + 4*DEPTH_WORDS). Word index is (addr - RAM_BASE) >> 2.
- Byte access: lane selected by addr[1:0]. Lane 0 is bits [7:0] (little-endian lanes).
- Halfword access: addr[0] must be 0; addr[1] selects the upper or lower half.
- Word access: addr[1:0] must be 00.
- Reads: rdata = selected lane(s) shifted to bit 0, upper bits 0.
  - Combinational from cs, rd, addr, size and the current RAM/register state.
  - rdata = 0 when there is no legal read this cycle.
- Writes: byte enables are derived from size and addr[1:0], and wdata is steered into the lanes. The RAM word updates at the edge.
- Read and write in the same cycle to the same word: rdata shows the pre-write contents.
- MMIO window: addr[31:4] == MMIO_BASE[31:4]. Word accesses only; halfword or byte access is an error.
  - 0x0 CYCLE: read-only. Increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0. Writes are ignored and are not errors.
  - 0x4 CMP: read/write.
  - 0x8 STATUS: bit0 MATCH, bit1 ERR, bits[15:8] ERRCNT, other bits read 0.
    - Writing 1 to bit0 or bit1 clears that bit (W1C).
    - Writing with wdata[31]=1 clears ERRCNT.
  - 0xC SCRATCH: read/write.
- MATCH sets at the edge where the pre-increment CYCLE equals CMP. Set takes priority over a W1C clear in the same cycle.
- err = cs and any of the following:
  - rd and wr both high;
  - rd and wr both low;
  - size == 11;
  - misaligned access;
  - address outside both regions;
  - non-word MMIO access.
- When err is high, no RAM or register write occurs and rdata = 0.
- On an err cycle, at the next edge: ERR sets; ERRCNT increments, saturating at 255.
  - Error set takes priority over a simultaneous W1C.
  - A simultaneous ERRCNT clear wins over the increment.
- irq = MATCH. It stays asserted until cleared by W1C or reset.
- cs low: no access, err = 0, rdata = 0. CYCLE and MATCH logic continue to run.
- Reset asserted mid-access: the register and RAM write in that cycle is suppressed.

Decomposition:
- Shared package holds:
  - size encodings (SZ_WORD, SZ_HALF, SZ_BYTE);
  - MMIO offsets (OFF_CYCLE, OFF_CMP, OFF_STATUS, OFF_SCRATCH);
  - STATUS bit positions.
- One sub-module, dmem_lane_steer: combinational.
  - Inputs: size, addr[1:0], wdata, raw RAM word.
  - Outputs: byte enables, steered write word, right-justified read data, misalign flag.
- The RAM array, MMIO registers and decode stay in dmem_responder.

Test Plan:
- Byte steering: write word 0x1122_3344 to 0x1001_0000, then byte-write 0xAB to 0x1001_0002 -> word read returns 0x11AB_3344; byte read of 0x1001_0003 returns 0x0000_0011.
- Halfword: half-write 0xBEEF to 0x1001_0006 -> half read returns 0x0000_BEEF and word read of 0x1001_0004 returns 0xBEEF_xxxx (lower half unchanged). Half access to 0x1001_0005 -> err=1, no write, STATUS = 0x0000_0102 next cycle.
- Errors: unmapped addr 0x0000_0000, byte access to MMIO, size 11, and rd+wr together, each on cs=1 -> err=1 each time; ERRCNT reaches 4. 260 consecutive errors -> ERRCNT = 255. Write 0x8000_0002 to STATUS -> STATUS = 0.
- Compare: after reset, write CMP = 20 -> irq rises at the edge after CYCLE reads 20. W1C of bit0 on the exact match edge leaves irq = 1; a later W1C clears it.
- CYCLE wrap: force or run CYCLE to 0xFFFF_FFFF -> next read returns 0. A write to CYCLE is ignored with err = 0.
- Reset: mid-sequence reset with cs&wr to SCRATCH -> SCRATCH = 0, irq = 0, STATUS = 0 after the edge; RAM data written earlier still reads back.
